mux_nto1_rr_reg: RTL and testbench
==================================

// Module: mux_nto1_rr_reg
// PURPOSE
//  Parametrised N-channel, W-bit registered multiplexer with valid/ready handshake.
//  Two selection modes: explicit select (sel port) or fair round-robin over valid channels.
//  Sits between several producer streams and one consumer; adds one register stage.
//  Tags every output word with the index of the channel it came from.
// PARAMETERS
//  WIDTH     8  data width per channel, in bits (>=1)
//  CHANNELS  4  number of input channels (>=2)
//  SELW      derived localparam = $clog2(CHANNELS), width of sel/out_ch
// PORTS
//  clk        in   1               rising-edge clock
//  rst        in   1               asynchronous, active-high reset
//  mode       in   1               0 = explicit select, 1 = round-robin
//  sel        in   SELW            channel index used when mode=0
//  in_valid   in   CHANNELS        per-channel valid; bit i belongs to channel i
//  in_data    in   CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
//  in_ready   out  CHANNELS        per-channel ready (combinational)
//  out_valid  out  1               output register holds a word
//  out_data   out  WIDTH           registered data
//  out_ch     out  SELW            channel index of out_data
//  out_ready  in   1               consumer accepts the word when out_valid=1
// BEHAVIOUR
//  - Reset (async, rst=1): out_valid=0, out_data=0, out_ch=0, rr pointer=0. in_ready=0 while rst=1.
//  - Output stage is a one-entry buffer with states EMPTY (out_valid=0) and FULL (out_valid=1).
//    load_en = !out_valid | out_ready. In FULL with out_ready=0, out_data/out_ch hold.
//  - Grant (combinational):
//      mode=0: grant=sel. If sel>=CHANNELS, there is no grant.
//      mode=1: grant = first i with in_valid[i]=1, scanning ptr, ptr+1, ... mod CHANNELS.
//              If no channel is valid, there is no grant.
//  - in_ready[i] = load_en & grant exists & (i==grant). All other bits are 0.
//    mode=0: in_ready[sel] does not depend on in_valid[sel].
//  - Transfer on channel g: a rising edge with in_valid[g] & in_ready[g].
//    On that edge: out_data <= channel g data, out_ch <= g, out_valid <= 1.
//  - out_valid <= 0 on an edge where out_valid & out_ready hold and no transfer occurs.
//  - Simultaneous drain and load (FULL, out_ready=1, transfer): the new word replaces the old
//    one with no bubble. Full throughput is 1 word/cycle.
//  - Latency: a word accepted at edge k is visible on out_* after edge k (1 cycle).
//  - RR pointer: updated only on a transfer made in mode=1: ptr <= (g+1) mod CHANNELS,
//    wrapping from CHANNELS-1 to 0. Transfers in mode=0 and idle cycles leave ptr unchanged.
//  - Changing mode or sel takes effect on the next grant only. A word already in the
//    output register is never altered or dropped.
//  - A producer holds data stable while valid=1 and ready=0. The block does not check this.
//  - Reset asserted mid-transfer discards the buffered word at once (out_valid=0).
//    No transfer completes on any edge where rst=1.
// TESTING (WIDTH=8, CHANNELS=4)
//  1 Reset: assert rst mid-stream with out_valid=1 -> out_valid/out_data/out_ch read 0
//    immediately, before the next clk edge. Release rst; the next mode=1 grant goes to ch0.
//  2 mode=0, sel=2, ch2 sends 0xA5 with out_ready=1 -> out_data=0xA5, out_ch=2 one cycle later;
//    in_ready=4'b0100. sel=3'd5 is not possible at SELW=2, so use CHANNELS=5 with sel=7
//    -> in_ready=0, no transfer.
//  3 mode=1, all 4 channels valid (data 0x10..0x13), out_ready=1 for 8 cycles -> out_ch sequence
//    0,1,2,3,0,1,2,3 back-to-back with no bubbles; ptr wraps 3->0.
//  4 Backpressure: out_ready=0 with the buffer FULL (0x33, ch3) for 5 cycles -> out_data/out_ch
//    stable, in_ready=0. Raise out_ready -> next word loads on the same edge.
//  5 mode=1, only ch1 and ch3 valid, ptr=2 -> grant order 3,1,3,1. Drop ch3 valid -> ch1 only,
//    no idle cycles.
//  6 Mode switch: with out_valid=1 and out_ready=0, switch mode 1->0 -> held word is unchanged;
//    the next transfer follows sel and ptr is retained for a later return to mode 1.

Source files
------------

// File: rtl/mux_nto1_rr_reg.sv
// N-channel registered multiplexer with valid/ready handshake.
// Selects a producer either by an explicit index or by round-robin over the
// valid channels. The selected word passes through a one-entry output
// register and is tagged with the index of the channel it came from.
//
// Output stage states:
//   state | meaning
//   EMPTY | output register holds no word, out_valid=0
//   FULL  | output register holds a word, out_valid=1
module mux_nto1_rr_reg #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    localparam int SELW    = $clog2(CHANNELS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        mode,
    input  logic [SELW-1:0]             sel,
    input  logic [CHANNELS-1:0]         in_valid,
    input  logic [CHANNELS*WIDTH-1:0]   in_data,
    output logic [CHANNELS-1:0]         in_ready,
    output logic                        out_valid,
    output logic [WIDTH-1:0]            out_data,
    output logic [SELW-1:0]             out_ch,
    input  logic                        out_ready
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [SELW-1:0]   ch_q, ch_d;
    logic [SELW-1:0]   ptr_q, ptr_d;

    logic              load_en;
    logic              rr_hi_found, rr_lo_found;
    logic [SELW-1:0]   rr_hi, rr_lo;
    logic              grant_valid;
    logic [SELW-1:0]   grant;
    logic [WIDTH-1:0]  grant_data;
    logic              xfer;

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;
    assign out_ch    = ch_q;
    assign load_en   = !out_valid || out_ready;

    // Round-robin search: the lowest valid index at or above the pointer wins;
    // failing that, the lowest valid index below the pointer (wrap-around).
    always_comb begin
        rr_hi_found = 1'b0;
        rr_lo_found = 1'b0;
        rr_hi       = '0;
        rr_lo       = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                if (i >= int'(ptr_q)) begin
                    rr_hi_found = 1'b1;
                    rr_hi       = SELW'(i);
                end else begin
                    rr_lo_found = 1'b1;
                    rr_lo       = SELW'(i);
                end
            end
        end
    end

    // Grant selection; an out-of-range sel in explicit mode grants nothing.
    always_comb begin
        grant_valid = 1'b0;
        grant       = '0;
        if (!mode) begin
            grant_valid = (int'(sel) < CHANNELS);
            grant       = sel;
        end else if (rr_hi_found) begin
            grant_valid = 1'b1;
            grant       = rr_hi;
        end else if (rr_lo_found) begin
            grant_valid = 1'b1;
            grant       = rr_lo;
        end
    end

    // One-hot ready towards the granted producer, plus the granted data word.
    always_comb begin
        in_ready   = '0;
        grant_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant == SELW'(i)) begin
                in_ready[i] = load_en && grant_valid && !rst;
                grant_data  = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign xfer = |(in_valid & in_ready);

    // Next state of the output buffer and the round-robin pointer.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ch_d    = ch_q;
        ptr_d   = ptr_q;
        if (xfer) begin
            state_d = FULL;
            data_d  = grant_data;
            ch_d    = grant;
            if (mode) begin
                ptr_d = (grant == SELW'(CHANNELS - 1)) ? '0 : grant + SELW'(1);
            end
        end else if ((state_q == FULL) && out_ready) begin
            state_d = EMPTY;
        end
    end

    // State registers; reset drops any buffered word immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            data_q  <= '0;
            ch_q    <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: tb/tb_mux_nto1_rr_reg.sv
// Directed testbench for mux_nto1_rr_reg: a 4-channel instance for most
// scenarios and a 5-channel instance for out-of-range select handling.
module tb_mux_nto1_rr_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_ready;

    logic        mode5;
    logic [2:0]  sel5;
    logic [4:0]  in_valid5;
    logic [39:0] in_data5;
    logic [4:0]  in_ready5;
    logic        out_valid5;
    logic [7:0]  out_data5;
    logic [2:0]  out_ch5;
    logic        out_ready5;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mux_nto1_rr_reg #(.WIDTH(8), .CHANNELS(4)) dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
        .out_ready(out_ready)
    );

    mux_nto1_rr_reg #(.WIDTH(8), .CHANNELS(5)) dut5 (
        .clk(clk), .rst(rst), .mode(mode5), .sel(sel5),
        .in_valid(in_valid5), .in_data(in_data5), .in_ready(in_ready5),
        .out_valid(out_valid5), .out_data(out_data5), .out_ch(out_ch5),
        .out_ready(out_ready5)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 1'b0; sel = 2'd0; in_valid = 4'b1111;
        in_data = 32'h13121110; out_ready = 1'b1;
        mode5 = 1'b0; sel5 = 3'd0; in_valid5 = 5'b0; in_data5 = 40'h6463626160; out_ready5 = 1'b1;
        tick();
        checks++;
        if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready); end
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0) begin
            errors++; $display("FAIL reset_out got v=%b d=%h c=%0d exp v=0 d=00 c=0", out_valid, out_data, out_ch);
        end
        #2 rst = 1'b0;
        // move ptr to 2 with a round-robin transfer on ch1
        mode = 1'b1; in_valid = 4'b0010; in_data = 32'h00002100; out_ready = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h21 || out_ch !== 2'd1) begin
            errors++; $display("FAIL reset_preload got v=%b d=%h c=%0d exp v=1 d=21 c=1", out_valid, out_data, out_ch);
        end
        // mid-cycle reset: outputs clear before any clock edge
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_ch !== 2'd0) begin
            errors++; $display("FAIL reset_async got v=%b d=%h c=%0d exp v=0 d=00 c=0", out_valid, out_data, out_ch);
        end
        in_valid = 4'b1111; in_data = 32'h13121110; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_held_ready got=%b exp=0000", in_ready); end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_no_xfer got v=%b exp v=0", out_valid); end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin errors++; $display("FAIL reset_ptr_ready got=%b exp=0001", in_ready); end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 8'h10) begin
            errors++; $display("FAIL reset_first_grant got v=%b d=%h c=%0d exp v=1 d=10 c=0", out_valid, out_data, out_ch);
        end
    endtask

    task automatic test_explicit();
        // ptr is 1 here; explicit-mode transfers must leave it alone
        mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; in_data = 32'h00A50000; out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0100) begin errors++; $display("FAIL sel2_ready got=%b exp=0100", in_ready); end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_ch !== 2'd2) begin
            errors++; $display("FAIL sel2_out got v=%b d=%h c=%0d exp v=1 d=a5 c=2", out_valid, out_data, out_ch);
        end
        in_valid = 4'b0000;
        #1;
        checks++;
        if (in_ready !== 4'b0100) begin errors++; $display("FAIL sel2_ready_novalid got=%b exp=0100", in_ready); end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL sel2_drain got v=%b exp v=0", out_valid); end
        // 5-channel instance: sel=7 is out of range
        sel5 = 3'd7; in_valid5 = 5'b11111;
        #1;
        checks++;
        if (in_ready5 !== 5'b00000) begin errors++; $display("FAIL sel7_ready got=%b exp=00000", in_ready5); end
        tick();
        checks++;
        if (out_valid5 !== 1'b0) begin errors++; $display("FAIL sel7_no_xfer got v=%b exp v=0", out_valid5); end
        sel5 = 3'd4;
        #1;
        checks++;
        if (in_ready5 !== 5'b10000) begin errors++; $display("FAIL sel4_ready got=%b exp=10000", in_ready5); end
        tick();
        checks++;
        if (out_valid5 !== 1'b1 || out_data5 !== 8'h64 || out_ch5 !== 3'd4) begin
            errors++; $display("FAIL sel4_out got v=%b d=%h c=%0d exp v=1 d=64 c=4", out_valid5, out_data5, out_ch5);
        end
        in_valid5 = 5'b0;
    endtask

    task automatic test_back_to_back();
        // ptr is 1: a lone ch3 transfer wraps ptr to 0
        mode = 1'b1; in_valid = 4'b1000; in_data = 32'h13121110; out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_ch !== 2'd3 || out_data !== 8'h13) begin
            errors++; $display("FAIL wrap_ch3 got v=%b d=%h c=%0d exp v=1 d=13 c=3", out_valid, out_data, out_ch);
        end
        in_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if (in_ready !== 4'(1 << (i % 4))) begin
                errors++; $display("FAIL rr_ready[%0d] got=%b exp=%b", i, in_ready, 4'(1 << (i % 4)));
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_ch !== 2'(i % 4) || out_data !== 8'(8'h10 + i % 4)) begin
                errors++; $display("FAIL rr_seq[%0d] got v=%b d=%h c=%0d exp v=1 d=%h c=%0d",
                                   i, out_valid, out_data, out_ch, 8'(8'h10 + i % 4), i % 4);
            end
        end
    endtask

    task automatic test_backpressure();
        // ptr is 0; load 0x33 from ch3, then stall
        in_valid = 4'b1000; in_data = 32'h33121110;
        tick();
        out_ready = 1'b0; in_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d] got=%b exp=0000", i, in_ready); end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h33 || out_ch !== 2'd3) begin
                errors++; $display("FAIL bp_hold[%0d] got v=%b d=%h c=%0d exp v=1 d=33 c=3", i, out_valid, out_data, out_ch);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0001) begin errors++; $display("FAIL bp_release_ready got=%b exp=0001", in_ready); end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h10 || out_ch !== 2'd0) begin
            errors++; $display("FAIL bp_release got v=%b d=%h c=%0d exp v=1 d=10 c=0", out_valid, out_data, out_ch);
        end
    endtask

    task automatic test_sparse();
        logic [1:0] exp_ch [4];
        exp_ch = '{2'd3, 2'd1, 2'd3, 2'd1};
        // ptr is 1: a ch1 transfer moves it to 2
        in_valid = 4'b0010; in_data = 32'h43004100;
        tick();
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_ch !== exp_ch[i] || out_data !== {6'h10, exp_ch[i]}) begin
                errors++; $display("FAIL sparse[%0d] got v=%b d=%h c=%0d exp v=1 d=%h c=%0d",
                                   i, out_valid, out_data, out_ch, {6'h10, exp_ch[i]}, exp_ch[i]);
            end
        end
        in_valid = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (in_ready !== 4'b0010) begin errors++; $display("FAIL ch1_only_ready[%0d] got=%b exp=0010", i, in_ready); end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== 8'h41) begin
                errors++; $display("FAIL ch1_only[%0d] got v=%b d=%h c=%0d exp v=1 d=41 c=1", i, out_valid, out_data, out_ch);
            end
        end
    endtask

    task automatic test_mode_switch();
        // buffer holds 0x41/ch1, ptr is 2
        out_ready = 1'b0;
        #1;
        mode = 1'b0; sel = 2'd3; in_valid = 4'b1111; in_data = 32'h53525150;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'h41 || out_ch !== 2'd1 || in_ready !== 4'b0000) begin
                errors++; $display("FAIL switch_hold[%0d] got v=%b d=%h c=%0d r=%b exp v=1 d=41 c=1 r=0000",
                                   i, out_valid, out_data, out_ch, in_ready);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b1000) begin errors++; $display("FAIL switch_sel_ready got=%b exp=1000", in_ready); end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h53 || out_ch !== 2'd3) begin
            errors++; $display("FAIL switch_sel got v=%b d=%h c=%0d exp v=1 d=53 c=3", out_valid, out_data, out_ch);
        end
        mode = 1'b1;
        #1;
        checks++;
        if (in_ready !== 4'b0100) begin errors++; $display("FAIL switch_ptr_kept got=%b exp=0100", in_ready); end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h52 || out_ch !== 2'd2) begin
            errors++; $display("FAIL switch_back_rr got v=%b d=%h c=%0d exp v=1 d=52 c=2", out_valid, out_data, out_ch);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_explicit();
        test_back_to_back();
        test_backpressure();
        test_sparse();
        test_mode_switch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
